// File: rtl/auth_resp_serializer_if.sv
// -----------------------------------------------------------------------------
// auth_resp_serializer_if
//
// Byte-serial stream from the authentication response serializer to the USB
// control-transfer engine.
//
//   tx_valid  serializer -> engine  tx_data/tx_stage/tx_last are valid
//   tx_data   serializer -> engine  byte being offered
//   tx_stage  serializer -> engine  0 = SETUP byte, 1 = DATA byte
//   tx_last   serializer -> engine  last byte of the current stage
//   tx_ready  engine -> serializer  engine accepts the byte this cycle
//
// A byte moves on a clock edge where tx_valid and tx_ready are both high.
// -----------------------------------------------------------------------------
interface auth_resp_serializer_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_stage;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_stage,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_stage,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/auth_resp_serializer.sv
// -----------------------------------------------------------------------------
// auth_resp_serializer
//
// Captures a finished authentication response when the responder raises
// msg_req_in, then streams it byte-serially to the USB control-transfer
// engine: an 8-byte SETUP stage followed by a DATA stage of len_eff bytes
// (header first, then payload, each most-significant byte first). Raises
// ack_out once the whole message has been sent, or pulses timeout_err if the
// sink stalls for current_timeout cycles.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   msg_req_in       responder request level
//   bmRequestType    SETUP byte 0
//   bRequest         SETUP byte 1
//   wLength          requested DATA length (clamped to the buffer size)
//   current_timeout  stall limit in cycles, 0 disables it
//   header           HDR_BYTES response header
//   payload          PAYLOAD_BYTES response payload
//   tx               byte stream to the engine (master side)
//   ack_out          message fully sent (level, held until msg_req_in drops)
//   timeout_err      one-cycle pulse when the stall limit is hit
//
// All outputs come straight from registers; their next values are derived
// from the next state and next counters so that byte 0 appears in the very
// first SETUP cycle.
// -----------------------------------------------------------------------------
module auth_resp_serializer #(
    parameter int HDR_BYTES     = 4,
    parameter int PAYLOAD_BYTES = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       msg_req_in,
    input  logic [7:0]                 bmRequestType,
    input  logic [7:0]                 bRequest,
    input  logic [15:0]                wLength,
    input  logic [31:0]                current_timeout,
    input  logic [8*HDR_BYTES-1:0]     header,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    auth_resp_serializer_if.master     tx,
    output logic                       ack_out,
    output logic                       timeout_err
);

    localparam int          TOTAL_BYTES = HDR_BYTES + PAYLOAD_BYTES;
    localparam logic [15:0] TOTAL_LEN   = 16'(TOTAL_BYTES);
    localparam int          IDX_W       = $clog2(TOTAL_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_DATA,
        S_ACK,
        S_TIMEOUT,
        S_WAIT_REL
    } state_t;

    state_t                   state_reg, state_next;
    logic [15:0]              cnt_reg, cnt_next;
    logic [31:0]              stall_reg, stall_next;

    // Message fields captured in LOAD.
    logic [7:0]               bm_reg, bm_next;
    logic [7:0]               breq_reg, breq_next;
    logic [15:0]              len_reg, len_next;
    logic [31:0]              tmo_reg, tmo_next;
    logic [8*TOTAL_BYTES-1:0] buf_reg, buf_next;

    // Registered outputs.
    logic                     tx_valid_reg, tx_valid_next;
    logic [7:0]               tx_data_reg, tx_data_next;
    logic                     tx_stage_reg, tx_stage_next;
    logic                     tx_last_reg, tx_last_next;
    logic                     ack_reg, ack_next;
    logic                     err_reg, err_next;

    logic                     xfer;
    logic [7:0]               setup_byte;
    logic [IDX_W-1:0]         data_idx;
    logic [7:0]               buf_bytes [TOTAL_BYTES];

    assign xfer = tx_valid_reg & tx.tx_ready;

    // DATA byte i is byte i of {header, payload} counted from the MSB end.
    genvar gi;
    generate
        for (gi = 0; gi < TOTAL_BYTES; gi++) begin : g_buf_bytes
            assign buf_bytes[gi] = buf_reg[8*(TOTAL_BYTES-1-gi) +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state, counters and capture
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_next = stall_reg;
        bm_next    = bm_reg;
        breq_next  = breq_reg;
        len_next   = len_reg;
        tmo_next   = tmo_reg;
        buf_next   = buf_reg;

        case (state_reg)
            S_IDLE: begin
                if (msg_req_in) begin
                    state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                bm_next    = bmRequestType;
                breq_next  = bRequest;
                len_next   = (wLength > TOTAL_LEN) ? TOTAL_LEN : wLength;
                tmo_next   = current_timeout;
                buf_next   = {header, payload};
                cnt_next   = 16'd0;
                stall_next = 32'd0;
                state_next = msg_req_in ? S_SETUP : S_IDLE;
            end

            S_SETUP, S_DATA: begin
                if (!msg_req_in) begin
                    state_next = S_IDLE;
                end else if (xfer) begin
                    // A transfer always clears the stall count, even if the
                    // limit would have been reached on this same edge.
                    stall_next = 32'd0;
                    if (tx_last_reg) begin
                        cnt_next = 16'd0;
                        if (state_reg == S_SETUP && len_reg != 16'd0) begin
                            state_next = S_DATA;
                        end else begin
                            state_next = S_ACK;
                        end
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end else if (tmo_reg != 32'd0) begin
                    // In these states tx_valid is always high, so no transfer
                    // means the sink stalled this cycle.
                    if (stall_reg + 32'd1 == tmo_reg) begin
                        state_next = S_TIMEOUT;
                    end else begin
                        stall_next = stall_reg + 32'd1;
                    end
                end
            end

            S_ACK: begin
                if (!msg_req_in) begin
                    state_next = S_IDLE;
                end
            end

            S_TIMEOUT: begin
                state_next = S_WAIT_REL;
            end

            S_WAIT_REL: begin
                if (!msg_req_in) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // SETUP byte for the next counter value; uses the capture values so the
    // first byte is correct on the LOAD -> SETUP edge.
    always_comb begin
        setup_byte = 8'h00;
        case (cnt_next[2:0])
            3'd0:    setup_byte = bm_next;
            3'd1:    setup_byte = breq_next;
            3'd6:    setup_byte = len_next[7:0];
            3'd7:    setup_byte = len_next[15:8];
            default: setup_byte = 8'h00;
        endcase
    end

    assign data_idx = cnt_next[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Output next values, decoded from next state and next counters
    // ------------------------------------------------------------------
    always_comb begin
        tx_valid_next = 1'b0;
        tx_data_next  = 8'h00;
        tx_stage_next = 1'b0;
        tx_last_next  = 1'b0;
        ack_next      = 1'b0;
        err_next      = 1'b0;

        case (state_next)
            S_SETUP: begin
                tx_valid_next = 1'b1;
                tx_data_next  = setup_byte;
                tx_last_next  = (cnt_next == 16'd7);
            end
            S_DATA: begin
                tx_valid_next = 1'b1;
                tx_stage_next = 1'b1;
                tx_data_next  = buf_bytes[data_idx];
                tx_last_next  = (cnt_next == len_reg - 16'd1);
            end
            S_ACK: begin
                ack_next = 1'b1;
            end
            S_TIMEOUT: begin
                err_next = 1'b1;
            end
            default: begin
                tx_valid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 16'd0;
            stall_reg    <= 32'd0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            tx_stage_reg <= 1'b0;
            tx_last_reg  <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            stall_reg    <= stall_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
            tx_stage_reg <= tx_stage_next;
            tx_last_reg  <= tx_last_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
        end
    end

    // Captured message fields are only read after LOAD has written them, so
    // they need no reset.
    always_ff @(posedge clk) begin
        bm_reg   <= bm_next;
        breq_reg <= breq_next;
        len_reg  <= len_next;
        tmo_reg  <= tmo_next;
        buf_reg  <= buf_next;
    end

    assign tx.tx_valid = tx_valid_reg;
    assign tx.tx_data  = tx_data_reg;
    assign tx.tx_stage = tx_stage_reg;
    assign tx.tx_last  = tx_last_reg;
    assign ack_out     = ack_reg;
    assign timeout_err = err_reg;

endmodule

// File: doc/auth_resp_serializer.md
# auth_resp_serializer

Downstream stage of the authentication responder. It captures a finished response (USB request fields plus header and payload) when the responder raises its request line. It then streams the response byte-serially to the USB control-transfer engine: an 8-byte SETUP stage first, then a DATA stage of `wLength` bytes. It returns an acknowledge level to the responder and enforces the per-message timeout supplied with the response.

## Interface
Parameters:
- HDR_BYTES, 4, header size in bytes.
- PAYLOAD_BYTES, 256, maximum payload size in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- msg_req_in  in  1  responder request level; high while a response is offered.
- bmRequestType  in  8  SETUP byte 0.
- bRequest  in  8  SETUP byte 1.
- wLength  in  16  DATA stage length in bytes.
- current_timeout  in  32  stall limit in cycles; 0 disables the limit.
- header  in  8*HDR_BYTES  response header; MSB byte is sent first.
- payload  in  8*PAYLOAD_BYTES  response payload; MSB byte is sent first.
- tx_ready  in  1  sink accepts the byte this cycle.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  8  byte being offered.
- tx_stage  out  1  0 = SETUP byte, 1 = DATA byte.
- tx_last  out  1  last byte of the current stage.
- ack_out  out  1  message fully sent; drives the responder's Ack_in.
- timeout_err  out  1  one-cycle pulse when a stall exceeds the limit.

## Operation
- States: IDLE, LOAD, SETUP, DATA, ACK, TIMEOUT, WAIT_REL.
- IDLE: all outputs are 0. If msg_req_in = 1, go to LOAD.
- LOAD (1 cycle):
  - Latch all input fields into internal registers.
  - len_eff = min(wLength, HDR_BYTES+PAYLOAD_BYTES).
  - Clear the byte counter and the stall counter.
  - Go to SETUP.
- SETUP: sends 8 bytes in this order:
  - bmRequestType, bRequest, 0x00, 0x00 (wValue), 0x00, 0x00 (wIndex), len_eff[7:0], len_eff[15:8].
  - tx_last = 1 on byte 7.
  - After byte 7 transfers, go to DATA if len_eff > 0, otherwise go to ACK.
- DATA: sends len_eff bytes in this order:
  - Header bytes first, MSB byte first.
  - Then payload bytes, MSB byte first.
  - Byte index i ≥ HDR_BYTES selects payload byte (i − HDR_BYTES), counted from the MSB end.
  - tx_last = 1 on byte len_eff−1. After that byte transfers, go to ACK.
- A byte transfers on a posedge where tx_valid = 1 and tx_ready = 1. The byte counter advances only on a transfer.
- ACK: ack_out = 1, tx_valid = 0. When msg_req_in = 0, go to IDLE.
- Stall counter:
  - Active in SETUP and DATA when the latched timeout ≠ 0.
  - Increments on each cycle with tx_valid = 1 and tx_ready = 0.
  - Clears on every transfer.
  - When it reaches the latched timeout, go to TIMEOUT.
- TIMEOUT (1 cycle): timeout_err = 1, tx_valid = 0. Go to WAIT_REL.
- WAIT_REL: all outputs are 0. When msg_req_in = 0, go to IDLE. No ack is ever raised after a timeout.
- Abort: msg_req_in = 0 in LOAD, SETUP or DATA sends the block to IDLE on the next edge. No ack and no error are raised.
- Inputs are sampled only in LOAD. Changes to the inputs during transmission have no effect.

## Timing
- Reset is synchronous and has priority over everything. The state is IDLE after the edge. tx_valid, tx_data, tx_stage, tx_last, ack_out and timeout_err are all 0.
- All outputs are registered and are a function of state and counters only.
- Edge sequence from a request:
  - Edge 1: msg_req_in is sampled high in IDLE; state becomes LOAD.
  - Edge 2: state becomes SETUP.
  - tx_valid = 1 with byte 0 during the cycle after edge 2.
- Latency:
  - With tx_ready held at 1, one byte transfers per cycle.
  - ack_out rises 1 + 1 + 8 + len_eff cycles after msg_req_in is first sampled high.
- tx_data and tx_last are held stable while tx_valid = 1 and tx_ready = 0.
- Timeout boundary: with limit T and tx_ready held low, timeout_err pulses exactly T cycles after tx_valid first stalls. T = 1 times out on the first stalled cycle.
- Simultaneous events: if a transfer and the stall limit coincide on the same edge, the transfer wins and the stall counter clears.
- Reset mid-transfer: no further bytes are sent. A held msg_req_in restarts the sequence from LOAD.
- When wLength exceeds the buffer, the clamped len_eff is used both in SETUP bytes 6–7 and as the DATA count.

## Test plan
- Digest response: wLength = 260, header = 0x01010000, payload bytes 0..255, tx_ready = 1 → SETUP bytes 80 18 00 00 00 00 04 01; then 260 DATA bytes 01 01 00 00 …; tx_last on DATA byte 259; ack_out rises 270 cycles after the request.
- Zero length: wLength = 0 → 8 SETUP bytes with tx_last on byte 7, no DATA stage, ack_out follows immediately.
- Backpressure: tx_ready toggles 1,0,0,1 … with current_timeout = 5 → identical byte sequence, no timeout_err, tx_data stable during every stall.
- Timeout: current_timeout = 3, tx_ready stuck at 0 from DATA byte 10 → timeout_err pulses once after 3 stalled cycles, no ack_out; a new request is accepted after msg_req_in falls.
- Abort and reset: drop msg_req_in at DATA byte 20 → IDLE next edge with all outputs 0; assert reset during SETUP byte 3 with msg_req_in held → restart from LOAD, SETUP byte 0 resent.
- Clamp: wLength = 0xFFFF → SETUP bytes 6–7 = 04 01; exactly 260 DATA bytes sent.
